// File: rtl/dec_scan_if.sv
// dec_scan_if: handshake bundle between a select source, the decoder and the
// consumer of the decoded lines.
//   in_valid / in_ready / in_sel : request side (index to decode)
//   out_valid / out_ready        : output handshake
//   y                            : decoded lines (N_OUT wide)
//   idx                          : index currently held in y
// Modports:
//   master : the environment (drives requests, takes outputs)
//   slave  : the decoder itself
interface dec_scan_if #(
  parameter int SEL_W = 4,
  parameter int N_OUT = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] y;
  logic [SEL_W-1:0] idx;

  modport master (
    output in_valid, in_sel, out_ready,
    input  in_ready, out_valid, y, idx
  );

  modport slave (
    input  in_valid, in_sel, out_ready,
    output in_ready, out_valid, y, idx
  );
endinterface

// File: rtl/dec_scan.sv
// dec_scan: registered N-of-2^SEL_W select decoder with valid/ready handshake
// and an optional autonomous scan mode.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous active-high reset
//   mode  : 0 = direct decode, 1 = scan (only with DEC_SCAN_EN)
//   bus   : dec_scan_if.slave (in_valid/in_ready/in_sel, out_valid/out_ready,
//           y, idx)
//   err   : sticky flag, set when an index >= N_OUT is decoded
// Configuration macro: DEC_SCAN_EN builds the SCAN state, the scan/dwell
// counters and the mode input. Without it the block is a plain decoder and
// DWELL is accepted but unused.
module dec_scan #(
  parameter int SEL_W      = 4,
  parameter int N_OUT      = 10,
  parameter int ACTIVE_LOW = 1,
  parameter int DWELL      = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     mode,
  dec_scan_if.slave bus,
  output logic     err
);

  localparam logic [N_OUT-1:0] INACTIVE = {N_OUT{ACTIVE_LOW != 0}};

  typedef enum logic {DIRECT, SCAN} state_t;

  state_t           state;
  logic [N_OUT-1:0] y_q;
  logic [SEL_W-1:0] idx_q;
  logic             out_valid_q;
  logic             load_ok;
  logic             in_ready_c;

  // One-hot (or one-cold) decode; indices past N_OUT leave every line inactive.
  function automatic logic [N_OUT-1:0] decode(input logic [SEL_W-1:0] sel);
    logic [N_OUT-1:0] hot;
    hot = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (int'(sel) == i) hot[i] = 1'b1;
    end
    return (ACTIVE_LOW != 0) ? ~hot : hot;
  endfunction

  function automatic logic out_of_range(input logic [SEL_W-1:0] sel);
    return int'(sel) >= N_OUT;
  endfunction

  // The output register can take a new word when empty or being drained.
  assign load_ok = !out_valid_q || bus.out_ready;

`ifdef DEC_SCAN_EN
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0]    DWELL_MAX = DW'(DWELL - 1);
  localparam logic [SEL_W-1:0] SCAN_MAX  = SEL_W'(N_OUT - 1);

  logic [SEL_W-1:0] scan_cnt;
  logic [DW-1:0]    dwell_cnt;

  // A pending mode=1 in DIRECT wins over a concurrent request.
  assign in_ready_c = !rst && load_ok && (state == DIRECT) && !mode;
`else
  localparam int unused_dwell = DWELL;
  logic unused_mode;
  assign unused_mode = mode;

  assign in_ready_c = !rst && load_ok;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.y         = y_q;
  assign bus.idx       = idx_q;
  assign bus.out_valid = out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= DIRECT;
      y_q         <= INACTIVE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      err         <= 1'b0;
`ifdef DEC_SCAN_EN
      scan_cnt    <= '0;
      dwell_cnt   <= '0;
`endif
    end else begin
      case (state)
        DIRECT: begin
          if (bus.in_valid && in_ready_c) begin
            y_q         <= decode(bus.in_sel);
            idx_q       <= bus.in_sel;
            out_valid_q <= 1'b1;
            if (out_of_range(bus.in_sel)) err <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
`ifdef DEC_SCAN_EN
          if (mode) begin
            state     <= SCAN;
            scan_cnt  <= '0;
            dwell_cnt <= '0;
          end
`endif
        end
`ifdef DEC_SCAN_EN
        SCAN: begin
          if (!mode) begin
            // Leaving scan: a held word stays until the consumer takes it.
            state     <= DIRECT;
            scan_cnt  <= '0;
            dwell_cnt <= '0;
            if (bus.out_ready) out_valid_q <= 1'b0;
          end else if (dwell_cnt == DWELL_MAX && load_ok) begin
            y_q         <= decode(scan_cnt);
            idx_q       <= scan_cnt;
            out_valid_q <= 1'b1;
            scan_cnt    <= (scan_cnt == SCAN_MAX) ? '0 : scan_cnt + 1'b1;
            dwell_cnt   <= '0;
          end else begin
            // Saturating dwell: a stall stretches the current slot.
            if (dwell_cnt != DWELL_MAX) dwell_cnt <= dwell_cnt + 1'b1;
            if (bus.out_ready) out_valid_q <= 1'b0;
          end
        end
`endif
        default: state <= DIRECT;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_scan.sv
// tb_dec_scan: directed test of dec_scan (SEL_W=4, N_OUT=10, ACTIVE_LOW=1,
// DWELL=2) with a cycle-level reference model checked every cycle plus
// literal spot checks. Scan scenarios run only when DEC_SCAN_EN is defined.
module tb_dec_scan;

  localparam int SEL_W = 4;
  localparam int N_OUT = 10;
  localparam int DWELL = 2;
`ifdef DEC_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode = 1'b0;
  logic err;

  int checkCount = 0;
  int passCount  = 0;

  dec_scan_if #(.SEL_W(SEL_W), .N_OUT(N_OUT)) bus ();

  dec_scan #(
    .SEL_W(SEL_W), .N_OUT(N_OUT), .ACTIVE_LOW(1), .DWELL(DWELL)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .bus(bus), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: what the outputs must be after each edge.
  logic [9:0] mY     = 10'h3FF;
  logic [3:0] mIdx   = 4'd0;
  logic       mValid = 1'b0;
  logic       mErr   = 1'b0;
  bit         mScan  = 1'b0;
  int         mAge   = 0;
  int         mNext  = 0;

  function automatic logic [9:0] expY(input int sel);
    logic [9:0] one;
    logic [9:0] hot;
    one = 10'd1;
    hot = (sel < N_OUT) ? (one << sel) : 10'd0;
    return ~hot;
  endfunction

  function automatic logic expReady();
    logic room;
    room = !mValid || bus.out_ready;
    return !rst && room && !(SCAN_EN && (mScan || mode));
  endfunction

  always @(posedge clk) begin
    logic room;
    logic take;
    room = !mValid || bus.out_ready;
    take = bus.in_valid && expReady();
    if (rst) begin
      mY = 10'h3FF; mIdx = 0; mValid = 0; mErr = 0;
      mScan = 0; mAge = 0; mNext = 0;
    end else if (!mScan) begin
      if (take) begin
        mY = expY(int'(bus.in_sel)); mIdx = bus.in_sel; mValid = 1;
        if (int'(bus.in_sel) >= N_OUT) mErr = 1;
      end else if (bus.out_ready) begin
        mValid = 0;
      end
      if (SCAN_EN && mode) begin
        mScan = 1; mAge = 0; mNext = 0;
      end
    end else if (!mode) begin
      mScan = 0;
      if (bus.out_ready) mValid = 0;
    end else begin
      mAge++;
      if (mAge >= DWELL && room) begin
        mY = expY(mNext); mIdx = 4'(mNext); mValid = 1;
        mNext = (mNext + 1) % N_OUT;
        mAge = 0;
      end else if (bus.out_ready) begin
        mValid = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    checkOutput("cmp_y", 32'(bus.y), 32'(mY));
    checkOutput("cmp_idx", 32'(bus.idx), 32'(mIdx));
    checkOutput("cmp_out_valid", 32'(bus.out_valid), 32'(mValid));
    checkOutput("cmp_err", 32'(err), 32'(mErr));
    checkOutput("cmp_in_ready", 32'(bus.in_ready), 32'(expReady()));
  end

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic applyStimulus(input logic r, input logic m, input logic v,
                               input logic [3:0] s, input logic ordy);
    rst = r; mode = m; bus.in_valid = v; bus.in_sel = s; bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_sel = '0; bus.out_ready = 1'b1;

    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("rst_y", 32'(bus.y), 32'h3FF);
    checkOutput("rst_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    checkOutput("rst_idx", 32'(bus.idx), 32'h0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'h0);

    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("idle_in_ready", 32'(bus.in_ready), 32'h1);

    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("dir0_y", 32'(bus.y), 32'h3FE);
    applyStimulus(0, 0, 1, 5, 1);
    checkOutput("dir5_y", 32'(bus.y), 32'h3DF);
    checkOutput("dir5_idx", 32'(bus.idx), 32'h5);
    applyStimulus(0, 0, 1, 9, 1);
    checkOutput("dir9_y", 32'(bus.y), 32'h1FF);

    applyStimulus(0, 0, 1, 12, 1);
    checkOutput("oor_y", 32'(bus.y), 32'h3FF);
    checkOutput("oor_idx", 32'(bus.idx), 32'hC);
    checkOutput("oor_err", 32'(err), 32'h1);
    applyStimulus(0, 0, 1, 3, 1);
    checkOutput("after_oor_y", 32'(bus.y), 32'h3F7);
    checkOutput("err_sticky", 32'(err), 32'h1);
    applyStimulus(0, 0, 0, 3, 1);
    checkOutput("drain_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("drain_y_hold", 32'(bus.y), 32'h3F7);

    applyStimulus(0, 0, 1, 2, 0);
    applyStimulus(0, 0, 1, 6, 0);
    checkOutput("bp_y_hold", 32'(bus.y), 32'h3FB);
    checkOutput("bp_in_ready", 32'(bus.in_ready), 32'h0);
    applyStimulus(0, 0, 1, 7, 1);
    checkOutput("bp_release_y", 32'(bus.y), 32'h37F);
    checkOutput("bp_release_valid", 32'(bus.out_valid), 32'h1);

    applyStimulus(0, 0, 1, 4, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_stall_y", 32'(bus.y), 32'h3FF);
    checkOutput("rst_stall_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("rst_clears_err", 32'(err), 32'h0);

`ifdef DEC_SCAN_EN
    applyStimulus(0, 1, 1, 8, 1);
    checkOutput("scan_entry_no_accept", 32'(bus.out_valid), 32'h0);
    for (int k = 0; k <= 16; k++) begin
      applyStimulus(0, 1, 1, 8, 1);
      checkOutput("scan_in_ready", 32'(bus.in_ready), 32'h0);
      applyStimulus(0, 1, 1, 8, 1);
      checkOutput("scan_idx", 32'(bus.idx), 32'(k % N_OUT));
      checkOutput("scan_y", 32'(bus.y), 32'(expY(k % N_OUT)));
    end
    checkOutput("scan_at6", 32'(bus.idx), 32'h6);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("rst_scan_y", 32'(bus.y), 32'h3FF);
    checkOutput("rst_scan_valid", 32'(bus.out_valid), 32'h0);
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("restart_idx", 32'(bus.idx), 32'h0);
    checkOutput("restart_valid", 32'(bus.out_valid), 32'h1);
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("stall_idx", 32'(bus.idx), 32'h0);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("stall_no_skip", 32'(bus.idx), 32'h1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 5, 1);
    checkOutput("back_direct_y", 32'(bus.y), 32'h3DF);
`else
    applyStimulus(0, 1, 1, 8, 1);
    checkOutput("mode_ignored_y", 32'(bus.y), 32'h2FF);
    checkOutput("mode_ignored_idx", 32'(bus.idx), 32'h8);
`endif

    applyStimulus(0, 0, 0, 0, 1);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
